// File: rtl/output_bit_sched_pkg.sv
// rtl/output_bit_sched_pkg.sv - shared types, defaults and helpers for the output bit scheduler
package output_bit_sched_pkg;

  localparam int DEF_IN_W     = 1894;
  localparam int DEF_N_BITS   = 128;
  localparam int DEF_GRP      = 8;
  localparam int DEF_EVAL_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  function automatic int grp_idx_w(input int n_bits, input int grp);
    return ((n_bits / grp) > 1) ? $clog2(n_bits / grp) : 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/output_bit_sched_if.sv
// rtl/output_bit_sched_if.sv - vector, evaluator and result signals of the output bit scheduler
interface output_bit_sched_if
  import output_bit_sched_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int N_BITS = DEF_N_BITS,
  parameter int GRP    = DEF_GRP
) ();
  localparam int GW = grp_idx_w(N_BITS, GRP);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_vec;
  logic [N_BITS-1:0] in_golden;
  logic [IN_W-1:0]   eval_vec;
  logic [GW-1:0]     eval_grp;
  logic              eval_issue;
  logic [GRP-1:0]    eval_res;
  logic              out_valid;
  logic              out_ready;
  logic [N_BITS-1:0] out_word;
  logic              out_mismatch;
  logic [31:0]       test_cnt;
  logic [31:0]       err_cnt;

  modport slave (
    input  in_valid, in_vec, in_golden, eval_res, out_ready,
    output in_ready, eval_vec, eval_grp, eval_issue, out_valid, out_word,
           out_mismatch, test_cnt, err_cnt
  );

  modport master (
    output in_valid, in_vec, in_golden, eval_res, out_ready,
    input  in_ready, eval_vec, eval_grp, eval_issue, out_valid, out_word,
           out_mismatch, test_cnt, err_cnt
  );

endinterface

// File: rtl/output_bit_tag_pipe.sv
// rtl/output_bit_tag_pipe.sv - valid+group-index delay line matching the evaluator bank latency
module output_bit_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [IDX_W-1:0] in_idx_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             busy_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];

  always_comb begin
    vld_d[0] = in_valid_i;
    idx_d[0] = in_idx_i;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // Only the valid bits need clearing; a stale index is never consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    idx_q <= idx_d;
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_idx_o   = idx_q[DEPTH-1];
  assign busy_o      = |vld_q;

endmodule

// File: rtl/output_bit_sched.sv
// rtl/output_bit_sched.sv - issues a captured vector group by group to a shared evaluator bank
// and assembles the returned bits into a word compared against the captured golden.
module output_bit_sched
  import output_bit_sched_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int N_BITS   = DEF_N_BITS,
  parameter int GRP      = DEF_GRP,
  parameter int EVAL_LAT = DEF_EVAL_LAT
) (
  input logic               clk,
  input logic               rst,
  output_bit_sched_if.slave bus
);

  localparam int N_GRPS = N_BITS / GRP;
  localparam int GW     = grp_idx_w(N_BITS, GRP);
  localparam logic [GW-1:0] LAST_GRP = GW'(N_GRPS - 1);

  if ((N_BITS % GRP) != 0) begin : g_bad_grp
    $error("N_BITS must be a multiple of GRP");
  end
  if ((EVAL_LAT < 1) || (EVAL_LAT > 4)) begin : g_bad_lat
    $error("EVAL_LAT must be within 1..4");
  end

  sched_state_e      state_q, state_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [IN_W-1:0]   vec_q, vec_d;
  logic [N_BITS-1:0] gold_q, gold_d;
  logic [N_BITS-1:0] word_q, word_d;
  logic              mism_q, mism_d;
  logic [31:0]       test_cnt_q, test_cnt_d;
  logic [31:0]       err_cnt_q, err_cnt_d;

  logic              capture;
  logic              done_entry;
  logic              tag_valid;
  logic [GW-1:0]     tag_idx;
  logic              tag_busy;

  output_bit_tag_pipe #(
    .DEPTH (EVAL_LAT),
    .IDX_W (GW)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.eval_issue),
    .in_idx_i    (grp_q),
    .out_valid_o (tag_valid),
    .out_idx_o   (tag_idx),
    .busy_o      (tag_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.in_valid)        state_d = ST_ISSUE;
      ST_ISSUE: if (grp_q == LAST_GRP)   state_d = ST_DRAIN;
      ST_DRAIN: if (!tag_busy)           state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready)       state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state_q == ST_IDLE);
    bus.eval_issue = (state_q == ST_ISSUE);
    bus.out_valid  = (state_q == ST_DONE);
  end

  assign capture    = bus.in_valid && (state_q == ST_IDLE);
  assign done_entry = (state_q == ST_DRAIN) && !tag_busy;

  always_comb begin
    vec_d      = vec_q;
    gold_d     = gold_q;
    word_d     = word_q;
    grp_d      = grp_q;
    mism_d     = mism_q;
    test_cnt_d = test_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (capture) begin
      vec_d  = bus.in_vec;
      gold_d = bus.in_golden;
      word_d = '0;
      grp_d  = '0;
      mism_d = 1'b0;
    end
    if (bus.eval_issue) begin
      grp_d = (grp_q == LAST_GRP) ? '0 : grp_q + 1'b1;
    end
    // eval_res belongs to the group leaving the tag pipe this cycle and is ignored otherwise.
    if (tag_valid) begin
      word_d[tag_idx*GRP +: GRP] = bus.eval_res;
    end
    if (done_entry) begin
      mism_d     = (word_q != gold_q);
      test_cnt_d = sat_inc(test_cnt_q);
      if (word_q != gold_q) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q      <= '0;
      word_q     <= '0;
      mism_q     <= 1'b0;
      test_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      grp_q      <= grp_d;
      word_q     <= word_d;
      mism_q     <= mism_d;
      test_cnt_q <= test_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    vec_q  <= vec_d;
    gold_q <= gold_d;
  end

  assign bus.eval_vec     = vec_q;
  assign bus.eval_grp     = grp_q;
  assign bus.out_word     = word_q;
  assign bus.out_mismatch = mism_q;
  assign bus.test_cnt     = test_cnt_q;
  assign bus.err_cnt      = err_cnt_q;

endmodule
